// File: rtl/pbs_pkg.sv
// Shared types and constants for the battle datapath blocks.
package pbs_pkg;

    localparam int VAL_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        ROLL,
        APPLY,
        DONE
    } state_t;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3).
    localparam logic [7:0] LFSR_TAPS       = 8'hB8;
    localparam logic [3:0] ALWAYS_HIT_ACCU = 4'hF;
    localparam logic [3:0] MAX_VAL         = 4'hF;

    // Next LFSR state; a zero state is recovered by reloading the seed.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur, input logic [7:0] seed);
        if (cur == 8'h00) begin
            return seed;
        end
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/attack_resolver_if.sv
// Request/result bundle between the move selector and the attack resolver.
interface attack_resolver_if #(
    parameter int VAL_W = pbs_pkg::VAL_W
);
    logic             start;
    logic [VAL_W-1:0] dmg;
    logic [VAL_W-1:0] accu;
    logic [VAL_W-1:0] target_hp;
    logic             dbg_roll_en;
    logic [VAL_W-1:0] dbg_roll;
    logic             busy;
    logic             done;
    logic             hit;
    logic             crit;
    logic [VAL_W-1:0] dmg_dealt;
    logic [VAL_W-1:0] new_hp;
    logic             ko;

    modport master (
        output start, dmg, accu, target_hp, dbg_roll_en, dbg_roll,
        input  busy, done, hit, crit, dmg_dealt, new_hp, ko
    );

    modport slave (
        input  start, dmg, accu, target_hp, dbg_roll_en, dbg_roll,
        output busy, done, hit, crit, dmg_dealt, new_hp, ko
    );
endinterface

// File: rtl/pbs_lfsr.sv
// Free-running 8-bit Fibonacci LFSR with zero-state recovery.
module pbs_lfsr
    import pbs_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [7:0] state_o
);

    logic [7:0] state_q;

    // Advance every clock; a zero state reloads the seed on the next edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SEED;
        end else begin
            state_q <= lfsr_next(state_q, SEED);
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/attack_resolver.sv
// Resolves one attack: latches operands, rolls, applies damage, pulses done.
module attack_resolver
    import pbs_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         VAL_W     = pbs_pkg::VAL_W
) (
    input  logic             clk,
    input  logic             reset_n,
    attack_resolver_if.slave bus
);

    localparam logic [VAL_W-1:0] MAX_V      = VAL_W'(MAX_VAL);
    localparam logic [VAL_W-1:0] ALWAYS_HIT = VAL_W'(ALWAYS_HIT_ACCU);

    state_t state_q, state_d;

    logic [7:0]       lfsr;
    logic [VAL_W-1:0] dmg_q, accu_q, hp_q, roll_q;
    logic             busy_q, done_q, hit_q, crit_q, ko_q;
    logic [VAL_W-1:0] dealt_q, newHp_q;

    logic             hitC, critC;
    logic [VAL_W:0]   dmgDouble;
    logic [VAL_W-1:0] dmgCrit, effC, newHpC, dealtC;

    // Only the low bits form the roll; the upper bits just carry the sequence.
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr[7:VAL_W];

    pbs_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .reset_n(reset_n),
        .state_o(lfsr)
    );

    // State register; reset aborts any resolution in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fixed five-step sequence; start is only looked at while idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LATCH;
            LATCH:   state_d = ROLL;
            ROLL:    state_d = APPLY;
            APPLY:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Hit/crit decision and saturating damage/HP arithmetic on latched operands.
    always_comb begin
        hitC      = (accu_q == ALWAYS_HIT) | (roll_q < accu_q);
        critC     = hitC & (roll_q == '0);
        dmgDouble = {dmg_q, 1'b0};
        dmgCrit   = (dmgDouble > {1'b0, MAX_V}) ? MAX_V : dmgDouble[VAL_W-1:0];
        effC      = '0;
        if (hitC) begin
            effC = critC ? dmgCrit : dmg_q;
        end
        newHpC = '0;
        dealtC = hp_q;
        if (effC < hp_q) begin
            newHpC = hp_q - effC;
            dealtC = effC;
        end
    end

    // Operand capture, roll capture, result update and handshake flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dmg_q   <= '0;
            accu_q  <= '0;
            hp_q    <= '0;
            roll_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
            crit_q  <= 1'b0;
            dealt_q <= '0;
            newHp_q <= '0;
            ko_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                LATCH: begin
                    dmg_q  <= bus.dmg;
                    accu_q <= bus.accu;
                    hp_q   <= bus.target_hp;
                    busy_q <= 1'b1;
                end
                ROLL: begin
                    roll_q <= bus.dbg_roll_en ? bus.dbg_roll : lfsr[VAL_W-1:0];
                end
                APPLY: begin
                    hit_q   <= hitC;
                    crit_q  <= critC;
                    dealt_q <= dealtC;
                    newHp_q <= newHpC;
                    ko_q    <= (newHpC == '0);
                end
                DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.hit       = hit_q;
    assign bus.crit      = crit_q;
    assign bus.dmg_dealt = dealt_q;
    assign bus.new_hp    = newHp_q;
    assign bus.ko        = ko_q;

endmodule

// File: doc/attack_resolver.md
Name: attack_resolver

Overview:
- Resolves one attack between move selection and HP update in the battle datapath.
- Accepts the selected move's damage and accuracy plus the target's current HP, rolls a pseudo-random 4-bit value, and decides hit, miss or critical.
- Returns the target's new HP, the damage dealt and a KO flag.
- Outputs drive the HP registers and the HP/damage 7-segment displays.

Parameters:
- LFSR_SEED, 8'hA5, reset value of the internal LFSR; must be nonzero.
- VAL_W, 4, width of damage, accuracy, HP and roll values.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- start  input  1  request to resolve one attack; sampled only in IDLE.
- dmg  input  VAL_W  base damage of the selected move (0..15).
- accu  input  VAL_W  accuracy (0 = never hits, 15 = always hits).
- target_hp  input  VAL_W  target's current HP.
- dbg_roll_en  input  1  when 1, dbg_roll replaces the LFSR roll; tied 0 in the top level.
- dbg_roll  input  VAL_W  forced roll value.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle.
- hit  output  1  attack connected.
- crit  output  1  critical hit.
- dmg_dealt  output  VAL_W  damage actually applied.
- new_hp  output  VAL_W  target HP after the attack.
- ko  output  1  new_hp == 0.

Behaviour:
- Reset values:
  - All outputs 0, FSM in IDLE, LFSR = LFSR_SEED.
  - Any reset, including mid-operation, aborts the resolution; no done is issued.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, period 255.
  - Free-runs every clock in all states.
  - If it ever reaches 0, it reloads LFSR_SEED on the next cycle.
- FSM states: IDLE, LATCH, ROLL, APPLY, DONE.
  - IDLE: on start=1, go to LATCH. While start=0, stay in IDLE and hold the previous results.
  - LATCH:
    - Register dmg, accu and target_hp; later input changes are ignored.
    - Set busy=1; go to ROLL.
  - ROLL:
    - Capture roll = dbg_roll_en ? dbg_roll : lfsr[3:0].
    - hit = (accu == 15) | (roll < accu). With accu = 0 this never hits.
    - crit = hit & (roll == 0).
    - Go to APPLY.
  - APPLY:
    - eff = hit ? (crit ? min(2*dmg, 15) : dmg) : 0.
    - Compute 2*dmg in 5 bits, then saturate to 15.
    - new_hp = (eff >= target_hp) ? 0 : target_hp - eff. Subtraction saturates; it never wraps.
    - dmg_dealt = min(eff, target_hp).
    - ko = (new_hp == 0).
    - Go to DONE.
  - DONE:
    - done=1 for exactly one cycle; busy=0.
    - Return to IDLE.
- Latency: start sampled at edge N gives done high in the cycle after edge N+4, four cycles after acceptance.
- Result outputs change only in APPLY and hold until the next APPLY.
- start asserted while busy or in DONE is ignored; it is not queued.
- start held high continuously re-triggers from IDLE, giving one resolution every 5 cycles.
- target_hp = 0 at latch: new_hp = 0, dmg_dealt = 0, ko = 1. hit/crit are still reported per the roll.

Decomposition:
- Shared package pbs_pkg holds:
  - VAL_W default
  - state enum (IDLE, LATCH, ROLL, APPLY, DONE)
  - LFSR tap mask 8'hB8
  - ALWAYS_HIT_ACCU = 4'hF
  - MAX_VAL = 4'hF
- Sub-module pbs_lfsr:
  - Ports: clk, reset_n, seed parameter, 8-bit state output.
  - Free-running, with zero-state recovery.
  - Reused later by the AI move picker.

Test Plan:
- dbg_roll=5, accu=8, dmg=3, target_hp=10, start pulse -> done 4 cycles after acceptance; hit=1, crit=0, dmg_dealt=3, new_hp=7, ko=0; busy high for the 3 cycles before done.
- dbg_roll=9, accu=8, dmg=6, target_hp=10 -> hit=0, crit=0, dmg_dealt=0, new_hp=10.
- dbg_roll=0, accu=8, dmg=6, target_hp=15 -> crit=1, dmg_dealt=12, new_hp=3; then dmg=9 -> saturated eff=15, new_hp=0, ko=1.
- Boundaries:
  - accu=15, dbg_roll=14, dmg=9, target_hp=4 -> hit=1, dmg_dealt=4, new_hp=0, ko=1.
  - accu=0, dbg_roll=0 -> hit=0, crit=0.
- Pulse start again during ROLL -> ignored, exactly one done.
- Deassert reset_n in APPLY -> all outputs 0 immediately, no done.
- After release, a new start completes normally.
- dbg_roll_en=0, run 300 cycles after reset -> LFSR never 0, sequence repeats with period 255.
- 16 back-to-back resolutions with the LFSR roll -> every result obeys the hit/crit/new_hp equations against the reference-model roll.
